// File: rtl/sys_array_ctrl.sv
// Control and address sequencer for a square systolic PE array: drives the shared
// enable/streamLength, feeder read addresses and the per-pass result write window.
module sys_array_ctrl #(
    parameter int SysDimension    = 16,
    parameter int InitialLantency = 45,
    parameter int DrainOffset     = 32,
    parameter int AddrWidth       = 12,
    parameter int CntWidth        = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [8:0]           cfgStreamLength,
    input  logic [7:0]           cfgNumPasses,
    input  logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic                 cfgErr,
    output logic                 arrayEnable,
    output logic [8:0]           arrayStreamLength,
    output logic                 inRdEn,
    output logic [AddrWidth-1:0] inRdAddr,
    output logic                 resWrEn,
    output logic [AddrWidth-1:0] resWrAddr,
    output logic [7:0]           passIdx
);

    localparam logic [8:0]          MinLen   = 9'(SysDimension);
    // Fill latency minus the stream-length term, which is only known at CONFIG.
    localparam logic [CntWidth-1:0] FillBase =
        CntWidth'(2 * (SysDimension - 1) + InitialLantency + 1 + DrainOffset);
    localparam int                  WcWidth  = $clog2(SysDimension + 1);
    localparam logic [WcWidth-1:0]  WcLast   = WcWidth'(SysDimension - 1);

    typedef enum logic [1:0] {IDLE, CONFIG, RUN, DONE} state_t;

    state_t                state;
    logic                  cfg_cnt;
    logic [8:0]            len;
    logic [7:0]            passes;
    logic [CntWidth-1:0]   ecnt;
    logic [CntWidth-1:0]   total;
    logic [CntWidth-1:0]   win_start;
    logic [WcWidth-1:0]    wr_cnt;
    logic [7:0]            pass;
    logic [AddrWidth-1:0]  wr_addr;

    logic in_window;
    logic last_write;

    // Writes within a pass are consecutive enabled cycles, so only the window start is tracked.
    assign in_window  = (ecnt >= win_start);
    assign last_write = (wr_cnt == WcLast) && ((pass + 8'd1) == passes);

    // NOTE: every register here uses <= so all updates see the pre-edge values;
    // the later state <= DONE intentionally overrides the earlier state <= RUN.
    always_ff @(posedge clk) begin
        // NOTE: latched configuration is cleared on reset/abort too, so every
        // output (including arrayStreamLength) returns to zero.
        if (!rst || abort) begin
            state             <= IDLE;
            cfg_cnt           <= 1'b0;
            len               <= '0;
            passes            <= '0;
            ecnt              <= '0;
            total             <= '0;
            win_start         <= '0;
            wr_cnt            <= '0;
            pass              <= '0;
            wr_addr           <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            cfgErr            <= 1'b0;
            arrayEnable       <= 1'b0;
            arrayStreamLength <= '0;
            inRdEn            <= 1'b0;
            inRdAddr          <= '0;
            resWrEn           <= 1'b0;
            resWrAddr         <= '0;
            passIdx           <= '0;
        end else begin
            done   <= 1'b0;
            cfgErr <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy        <= 1'b0;
                    arrayEnable <= 1'b0;
                    inRdEn      <= 1'b0;
                    resWrEn     <= 1'b0;
                    if (start) begin
                        if (cfgStreamLength < MinLen || cfgNumPasses == 8'd0) begin
                            cfgErr <= 1'b1;
                        end else begin
                            len               <= cfgStreamLength;
                            passes            <= cfgNumPasses;
                            arrayStreamLength <= cfgStreamLength;
                            busy              <= 1'b1;
                            cfg_cnt           <= 1'b0;
                            ecnt              <= '0;
                            wr_cnt            <= '0;
                            pass              <= '0;
                            wr_addr           <= '0;
                            state             <= CONFIG;
                        end
                    end
                end
                CONFIG, RUN: begin
                    if (state == CONFIG && !cfg_cnt) begin
                        cfg_cnt   <= 1'b1;
                        win_start <= FillBase + CntWidth'(len);
                        total     <= CntWidth'(len) * CntWidth'(passes);
                    end else begin
                        // The CONFIG exit edge already issues the first enabled cycle.
                        state <= RUN;
                        if (stall) begin
                            arrayEnable <= 1'b0;
                            inRdEn      <= 1'b0;
                            resWrEn     <= 1'b0;
                        end else begin
                            arrayEnable <= 1'b1;
                            inRdEn      <= (ecnt < total);
                            inRdAddr    <= AddrWidth'(ecnt);
                            ecnt        <= ecnt + CntWidth'(1);
                            resWrEn     <= in_window;
                            if (in_window) begin
                                resWrAddr <= wr_addr;
                                passIdx   <= pass;
                                wr_addr   <= wr_addr + AddrWidth'(1);
                                if (wr_cnt == WcLast) begin
                                    wr_cnt    <= '0;
                                    pass      <= pass + 8'd1;
                                    win_start <= win_start + CntWidth'(len);
                                    if (last_write) begin
                                        state <= DONE;
                                    end
                                end else begin
                                    wr_cnt <= wr_cnt + WcWidth'(1);
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    done        <= 1'b1;
                    busy        <= 1'b1;
                    arrayEnable <= 1'b0;
                    inRdEn      <= 1'b0;
                    resWrEn     <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_array_ctrl.sv
// Randomized self-checking bench for sys_array_ctrl; expected strobes and addresses
// come from the fill/window arithmetic applied to the enabled-cycle index.
module tb_sys_array_ctrl;

    localparam int D  = 4;
    localparam int IL = 3;
    localparam int DO = 8;
    localparam int AW = 12;
    localparam int CW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [8:0]    cfg_len;
    logic [7:0]    cfg_passes;
    logic          stall;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic          array_enable;
    logic [8:0]    array_len;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    pass_idx;

    int n_checks = 0;
    int n_bad    = 0;

    sys_array_ctrl #(
        .SysDimension   (D),
        .InitialLantency(IL),
        .DrainOffset    (DO),
        .AddrWidth      (AW),
        .CntWidth       (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .cfgStreamLength  (cfg_len),
        .cfgNumPasses     (cfg_passes),
        .stall            (stall),
        .busy             (busy),
        .done             (done),
        .cfgErr           (cfg_err),
        .arrayEnable      (array_enable),
        .arrayStreamLength(array_len),
        .inRdEn           (rd_en),
        .inRdAddr         (rd_addr),
        .resWrEn          (wr_en),
        .resWrAddr        (wr_addr),
        .passIdx          (pass_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"},     busy,         0);
        check({tag, ".done"},     done,         0);
        check({tag, ".cfg_err"},  cfg_err,      0);
        check({tag, ".enable"},   array_enable, 0);
        check({tag, ".len"},      array_len,    0);
        check({tag, ".rd_en"},    rd_en,        0);
        check({tag, ".rd_addr"},  rd_addr,      0);
        check({tag, ".wr_en"},    wr_en,        0);
        check({tag, ".wr_addr"},  wr_addr,      0);
        check({tag, ".pass_idx"}, pass_idx,     0);
    endtask

    task automatic cfg_reject(input int len, input int np);
        @(negedge clk);
        cfg_len    = 9'(len);
        cfg_passes = 8'(np);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rej.cfg_err", cfg_err, 1);
        check("rej.busy", busy, 0);
        check("rej.enable", array_enable, 0);
        @(negedge clk);
        check("rej.cfg_err_clr", cfg_err, 0);
        check("rej.busy_after", busy, 0);
        check("rej.enable_after", array_enable, 0);
    endtask

    // kill_mode: 0 none, 1 abort, 2 reset, applied on the edge that would issue E=kill_e.
    task automatic run_job(input int len, input int np,
                           input int s_at0, input int s_len0,
                           input int s_at1, input int s_len1,
                           input bit rand_stall,
                           input int kill_mode, input int kill_e,
                           input bit hold_start);
        int f, n_en, e, used0, used1, stalls, q, r, en_obs, reads, writes;
        bit st, exp_wr;
        f      = 2 * (D - 1) + len + IL + 1 + DO;
        n_en   = f + (np - 1) * len + D;
        e      = 0;
        used0  = 0;
        used1  = 0;
        stalls = 0;
        en_obs = 0;
        reads  = 0;
        writes = 0;

        @(negedge clk);
        cfg_len    = 9'(len);
        cfg_passes = 8'(np);
        start      = 1'b1;
        stall      = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            check("cfg.busy", busy, 1);
            check("cfg.enable", array_enable, 0);
            check("cfg.len", array_len, 32'(len));
            check("cfg.rd_en", rd_en, 0);
            check("cfg.wr_en", wr_en, 0);
        end

        while (e < n_en) begin
            if (kill_mode != 0 && e == kill_e) begin
                if (kill_mode == 1) abort = 1'b1;
                else rst = 1'b0;
                start = 1'b0;
                stall = 1'b0;
                @(negedge clk);
                check_all_zero(kill_mode == 1 ? "abort" : "rst");
                abort = 1'b0;
                rst   = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("kill.busy", busy, 0);
                    check("kill.done", done, 0);
                    check("kill.enable", array_enable, 0);
                end
                return;
            end
            st = 1'b0;
            if (e == s_at0 && used0 < s_len0) begin
                st = 1'b1;
                used0++;
            end else if (e == s_at1 && used1 < s_len1) begin
                st = 1'b1;
                used1++;
            end else if (rand_stall && stalls < 20 && $urandom_range(0, 3) == 0) begin
                st = 1'b1;
            end
            if (st) stalls++;
            stall = st;

            @(negedge clk);
            check("run.busy", busy, 1);
            check("run.done", done, 0);
            check("run.len", array_len, 32'(len));
            check("run.enable", array_enable, {31'd0, !st});
            if (array_enable) en_obs++;
            if (rd_en) reads++;
            if (wr_en) writes++;
            if (st) begin
                check("stall.rd_en", rd_en, 0);
                check("stall.wr_en", wr_en, 0);
            end else begin
                check("rd_en", rd_en, {31'd0, e < len * np});
                if (e < len * np) check("rd_addr", rd_addr, 32'(e % (1 << AW)));
                exp_wr = 1'b0;
                q = 0;
                r = 0;
                if (e >= f) begin
                    q = (e - f) / len;
                    r = (e - f) % len;
                    exp_wr = (q < np) && (r < D);
                end
                check("wr_en", wr_en, {31'd0, exp_wr});
                if (exp_wr) begin
                    check("wr_addr", wr_addr, 32'(q * D + r));
                    check("pass_idx", pass_idx, 32'(q));
                end
                e++;
            end
        end

        stall = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("done.pulse", done, 1);
        check("done.busy", busy, 1);
        check("done.enable", array_enable, 0);
        check("done.rd_en", rd_en, 0);
        check("done.wr_en", wr_en, 0);
        @(negedge clk);
        check("done.clear", done, 0);
        check("idle.busy", busy, 0);
        check("job.enabled_cycles", 32'(en_obs), 32'(n_en));
        check("job.reads", 32'(reads), 32'(len * np));
        check("job.writes", 32'(writes), 32'(np * D));
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        stall      = 1'b0;
        cfg_len    = '0;
        cfg_passes = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // Plain job: F=24, 40 enabled cycles.
        run_job(6, 3, -1, 0, -1, 0, 1'b0, 0, -1, 1'b0);
        // Same job with stalls at E=10 (5 cycles) and mid-write at E=25 (3 cycles).
        run_job(6, 3, 10, 5, 25, 3, 1'b0, 0, -1, 1'b0);
        // Rejected configurations.
        cfg_reject(3, 2);
        cfg_reject(6, 0);
        // Abort mid-run, then the minimum-length job.
        run_job(6, 3, -1, 0, -1, 0, 1'b0, 1, 20, 1'b0);
        run_job(4, 1, -1, 0, -1, 0, 1'b0, 0, -1, 1'b0);
        // Stall on the final write cycle.
        run_job(4, 2, 29, 2, -1, 0, 1'b0, 0, -1, 1'b0);
        // Reset mid-run with start held, then a full job with start held through RUN.
        run_job(6, 3, -1, 0, -1, 0, 1'b0, 2, 15, 1'b1);
        run_job(5, 2, -1, 0, -1, 0, 1'b0, 0, -1, 1'b1);

        for (int j = 0; j < 8; j++) begin
            run_job(int'($urandom_range(4, 10)), int'($urandom_range(1, 4)),
                    -1, 0, -1, 0, 1'b1, 0, -1, j[0]);
            if ($urandom_range(0, 1) == 1) cfg_reject(int'($urandom_range(0, 3)), 2);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
